// File: rtl/ht_detect_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package ht_detect_pkg;

    localparam int UART_BYTE_W   = 8;
    // Watchdog default: 50 ms at the 12 MHz board clock.
    localparam int TIMEOUT_12MHZ = 600000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_WAIT_BYTE = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from rr_ptr+1,
// wrapping modulo N_REQ.
module rr_arbiter
    import ht_detect_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] w_cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            // rr_ptr < N_REQ and offset <= N_REQ, so one subtraction wraps it.
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(N_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                              : w_sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[w_cand[k]]) begin
                any    = 1'b1;
                winner = w_cand[k];
            end
        end
        if (any) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin sharing of one UART transmitter between N_REQ byte-stream
// requesters, with a per-grant stall watchdog.
module uart_tx_arbiter
    import ht_detect_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = TIMEOUT_12MHZ
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0]               byte_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0]   byte_data,
    input  logic [N_REQ-1:0]               byte_last,
    output logic [N_REQ-1:0]               byte_ready,
    output logic [N_REQ-1:0]               grant,
    output logic [UART_BYTE_W-1:0]         tx_data_in,
    output logic                           tx_data_valid,
    input  logic                           bps_en_tx,
    output logic                           timeout_err
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(N_REQ - 1);

    arb_state_t             r_state,        w_state_next;
    logic [N_REQ-1:0]       r_grant,        w_grant_next;
    logic [IDX_W-1:0]       r_gidx,         w_gidx_next;
    logic [IDX_W-1:0]       r_rr,           w_rr_next;
    logic [WD_W-1:0]        r_wdog,         w_wdog_next;
    logic                   r_last,         w_last_next;
    logic [UART_BYTE_W-1:0] r_tx_data,      w_tx_data_next;
    logic                   r_tx_valid,     w_tx_valid_next;
    logic [N_REQ-1:0]       r_byte_ready,   w_byte_ready_next;
    logic                   r_timeout_err,  w_timeout_err_next;

    logic [UART_BYTE_W-1:0] w_bytes [N_REQ];
    logic [N_REQ-1:0]       w_arb_grant;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_any;
    logic                   w_owner_req;
    logic                   w_owner_valid;
    logic                   w_owner_last;
    logic [WD_W-1:0]        w_wdog_inc;
    logic                   w_wdog_expire;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_bytes[gi] = byte_data[gi*UART_BYTE_W +: UART_BYTE_W];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (r_rr),
        .grant  (w_arb_grant),
        .winner (w_arb_idx),
        .any    (w_arb_any)
    );

    assign w_owner_req   = req[r_gidx];
    assign w_owner_valid = byte_valid[r_gidx];
    assign w_owner_last  = byte_last[r_gidx];

    // Saturating increment; the limit itself triggers the forced release.
    assign w_wdog_inc    = (r_wdog == WD_LIMIT) ? r_wdog : r_wdog + WD_W'(1);
    assign w_wdog_expire = (w_wdog_inc == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_rr          <= RR_INIT;
            r_wdog        <= '0;
            r_last        <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_byte_ready  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_gidx        <= w_gidx_next;
            r_rr          <= w_rr_next;
            r_wdog        <= w_wdog_next;
            r_last        <= w_last_next;
            r_tx_data     <= w_tx_data_next;
            r_tx_valid    <= w_tx_valid_next;
            r_byte_ready  <= w_byte_ready_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_gidx_next        = r_gidx;
        w_rr_next          = r_rr;
        w_wdog_next        = r_wdog;
        w_last_next        = r_last;
        w_tx_data_next     = r_tx_data;
        w_tx_valid_next    = 1'b0;
        w_byte_ready_next  = '0;
        w_timeout_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_next = ST_ARB;
                end
            end

            ST_ARB: begin
                if (w_arb_any) begin
                    w_grant_next = w_arb_grant;
                    w_gidx_next  = w_arb_idx;
                    w_rr_next    = w_arb_idx;
                    w_wdog_next  = '0;
                    w_state_next = ST_WAIT_BYTE;
                end else begin
                    w_grant_next = '0;
                    w_state_next = ST_IDLE;
                end
            end

            ST_WAIT_BYTE: begin
                if (!w_owner_req) begin
                    w_grant_next = '0;
                    w_state_next = ST_IDLE;
                end else if (w_owner_valid && !bps_en_tx) begin
                    w_tx_data_next    = w_bytes[r_gidx];
                    w_byte_ready_next = r_grant;
                    w_last_next       = w_owner_last;
                    w_wdog_next       = '0;
                    w_state_next      = ST_LAUNCH;
                end else begin
                    w_wdog_next = w_wdog_inc;
                    if (w_wdog_expire) begin
                        w_timeout_err_next = 1'b1;
                        w_grant_next       = '0;
                        w_state_next       = ST_IDLE;
                    end
                end
            end

            ST_LAUNCH: begin
                w_tx_valid_next = 1'b1;
                w_state_next    = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                w_wdog_next = w_wdog_inc;
                if (w_wdog_expire) begin
                    w_timeout_err_next = 1'b1;
                    w_grant_next       = '0;
                    w_state_next       = ST_IDLE;
                end else if (bps_en_tx) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                w_wdog_next = w_wdog_inc;
                if (w_wdog_expire) begin
                    w_timeout_err_next = 1'b1;
                    w_grant_next       = '0;
                    w_state_next       = ST_IDLE;
                end else if (!bps_en_tx) begin
                    if (r_last) begin
                        w_grant_next = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_BYTE;
                    end
                end
            end

            default: begin
                w_grant_next = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign byte_ready    = r_byte_ready;
    assign grant         = r_grant;
    assign tx_data_in    = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: drivers push expected UART bytes, a monitor pops them.
module tb_uart_tx_arbiter;

    localparam int N    = 2;
    localparam int TO   = 50;
    localparam int BUSY = 20;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   byte_valid = '0;
    logic [N-1:0]   byte_last = '0;
    logic [7:0]     bd [N];
    logic [8*N-1:0] byte_data;
    logic [N-1:0]   byte_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data_in;
    logic           tx_data_valid;
    logic           bps_en_tx;
    logic           timeout_err;

    typedef struct packed {
        logic [3:0] owner;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_ready [N];
    int   act_ready [N];
    int   n_timeouts = 0;
    int   uart_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        byte_data = '0;
        for (int i = 0; i < N; i++) byte_data[8*i +: 8] = bd[i];
    end

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_last     (byte_last),
        .byte_ready    (byte_ready),
        .grant         (grant),
        .tx_data_in    (tx_data_in),
        .tx_data_valid (tx_data_valid),
        .bps_en_tx     (bps_en_tx),
        .timeout_err   (timeout_err)
    );

    // UART model: busy for BUSY cycles after each start pulse.
    always @(posedge clk) begin
        if (reset) begin
            uart_cnt  <= 0;
            bps_en_tx <= 1'b0;
        end else if (tx_data_valid) begin
            uart_cnt  <= BUSY;
            bps_en_tx <= 1'b1;
        end else if (uart_cnt > 1) begin
            uart_cnt  <= uart_cnt - 1;
        end else begin
            uart_cnt  <= 0;
            bps_en_tx <= 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic push_exp(input int idx, input logic [7:0] data);
        exp_q.push_back({4'(idx), data});
        exp_ready[idx]++;
    endtask

    // Monitor: pops one expected byte per UART start pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_data_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got byte %0h from grant %0b, expected none", tx_data_in, grant);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("tx byte %02h grant %0b (expected %02h owner %0d)", tx_data_in, grant, e.data, e.owner);
                    check("tx_data", int'(tx_data_in), int'(e.data));
                    check("tx_owner", int'(grant), 1 << e.owner);
                    check("tx_uart_idle", int'(bps_en_tx), 0);
                end
            end
            if (byte_ready != '0) begin
                check("ready_to_granted", int'(byte_ready & ~grant), 0);
                for (int i = 0; i < N; i++) if (byte_ready[i]) act_ready[i]++;
            end
            if (timeout_err) n_timeouts++;
        end
    end

    task automatic send_frame(input int idx, input logic [31:0] bytes, input int n, input bit hold);
        int k;
        req[idx] = 1'b1;
        for (int i = 0; i < n; i++) begin
            bd[idx]         = bytes[8*i +: 8];
            byte_last[idx]  = (i == n - 1);
            byte_valid[idx] = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!byte_ready[idx] && k < 2000);
            check($sformatf("ready_wait_r%0d_b%0d", idx, i), int'(byte_ready[idx]), 1);
            byte_valid[idx] = 1'b0;
            byte_last[idx]  = 1'b0;
        end
        if (!hold) req[idx] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (grant != '0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(grant), 0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        byte_valid = '0;
        byte_last  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        bd[0] = 8'h00;
        bd[1] = 8'h00;
        for (int i = 0; i < N; i++) begin
            exp_ready[i] = 0;
            act_ready[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_byte_ready", int'(byte_ready), 0);
        check("rst_tx_data_in", int'(tx_data_in), 0);
        check("rst_tx_data_valid", int'(tx_data_valid), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        reset = 1'b0;

        // 1) single requester, three-byte frame
        push_exp(0, 8'h41); push_exp(0, 8'h54); push_exp(0, 8'h0D);
        send_frame(0, 32'h000D5441, 3, 1'b0);
        wait_idle("t1_release");

        // 2) simultaneous requests after reset: req0 then req1
        do_reset();
        push_exp(0, 8'h41); push_exp(0, 8'h42);
        push_exp(1, 8'h43); push_exp(1, 8'h44);
        fork
            send_frame(0, 32'h00004241, 2, 1'b0);
            send_frame(1, 32'h00004443, 2, 1'b0);
        join
        wait_idle("t2_release");

        // 3) req1 finishes while both still requesting -> req0 next
        do_reset();
        push_exp(1, 8'h31); push_exp(1, 8'h32);
        push_exp(0, 8'h33);
        push_exp(1, 8'h34);
        fork
            begin
                send_frame(1, 32'h00003231, 2, 1'b1);
                send_frame(1, 32'h00000034, 1, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                send_frame(0, 32'h00000033, 1, 1'b0);
            end
        join
        wait_idle("t3_release");

        // 4) granted requester stalls -> watchdog release, other requester next
        do_reset();
        req = 2'b11;
        k = 0;
        while (grant == '0 && k < 100) begin @(negedge clk); k++; end
        check("t4_first_grant", int'(grant), 1);
        k = 0;
        while (!timeout_err && k < 200) begin @(negedge clk); k++; end
        check("t4_timeout_cycles", k, TO);
        check("t4_grant_released", int'(grant), 0);
        req[0] = 1'b0;
        k = 0;
        while (grant == '0 && k < 100) begin @(negedge clk); k++; end
        check("t4_next_grant", int'(grant), 2);
        push_exp(1, 8'h5A);
        send_frame(1, 32'h0000005A, 1, 1'b0);
        wait_idle("t4_release");

        // 5) reset while the UART is being started
        do_reset();
        push_exp(0, 8'h58);
        req[0] = 1'b1; bd[0] = 8'h58; byte_last[0] = 1'b1; byte_valid[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!byte_ready[0] && k < 100);
        check("t5_ready", int'(byte_ready[0]), 1);
        byte_valid[0] = 1'b0; byte_last[0] = 1'b0; req[0] = 1'b0;
        k = 0;
        while (!tx_data_valid && k < 100) begin @(negedge clk); k++; end
        check("t5_launch", int'(tx_data_valid), 1);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t5_rst_grant", int'(grant), 0);
        check("t5_rst_tx_valid", int'(tx_data_valid), 0);
        check("t5_rst_tx_data", int'(tx_data_in), 0);
        reset = 1'b0;
        push_exp(0, 8'h41); push_exp(0, 8'h54);
        send_frame(0, 32'h00005441, 2, 1'b0);
        wait_idle("t5_release");

        // 6) non-granted requester keeps byte_valid high
        do_reset();
        bd[1] = 8'hEE; byte_last[1] = 1'b1; byte_valid[1] = 1'b1;
        push_exp(0, 8'h10); push_exp(0, 8'h20); push_exp(0, 8'h30);
        send_frame(0, 32'h00302010, 3, 1'b0);
        wait_idle("t6_release");
        byte_valid[1] = 1'b0; byte_last[1] = 1'b0;
        repeat (5) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        for (int i = 0; i < N; i++) check($sformatf("ready_count_r%0d", i), act_ready[i], exp_ready[i]);
        check("timeout_pulses", n_timeouts, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
